// File: rtl/procyon_lib_pkg.sv
// Shared Procyon types: debounce lane state encoding and counter sizing helper.
package procyon_lib_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } lane_state_e;

    function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/procyon_debounce_lane.sv
// Single-lane debouncer: four-state FSM plus run counter, all outputs registered.
module procyon_debounce_lane
    import procyon_lib_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic data,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned       CW       = debounce_cnt_width(N);
    localparam logic [CW-1:0]     CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

    lane_state_e   state, state_nx;
    logic [CW-1:0] count, count_nx;
    logic          level_nx, rise_nx, fall_nx, busy_nx;

    always_comb begin
        state_nx = state;
        count_nx = count;
        level_nx = level;
        rise_nx  = 1'b0;
        fall_nx  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (data) begin
                    state_nx = PEND_HI;
                    count_nx = CNT_ONE;
                end
            end
            PEND_HI: begin
                if (!data) begin
                    state_nx = STABLE_LO;
                    count_nx = '0;
                end else if (count == CNT_LAST) begin
                    state_nx = STABLE_HI;
                    count_nx = '0;
                    level_nx = 1'b1;
                    rise_nx  = 1'b1;
                end else begin
                    count_nx = count + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!data) begin
                    state_nx = PEND_LO;
                    count_nx = CNT_ONE;
                end
            end
            PEND_LO: begin
                if (data) begin
                    state_nx = STABLE_HI;
                    count_nx = '0;
                end else if (count == CNT_LAST) begin
                    state_nx = STABLE_LO;
                    count_nx = '0;
                    level_nx = 1'b0;
                    fall_nx  = 1'b1;
                end else begin
                    count_nx = count + CNT_ONE;
                end
            end
            default: begin
                state_nx = STABLE_LO;
                count_nx = '0;
            end
        endcase
        busy_nx = (state_nx == PEND_HI) || (state_nx == PEND_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_VAL ? STABLE_HI : STABLE_LO;
            count <= '0;
            level <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            level <= level_nx;
            rise  <= rise_nx;
            fall  <= fall_nx;
            busy  <= busy_nx;
        end
    end

    // Structural invariants of the lane: bounded counter, exclusive single-cycle pulses.
    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CNT_LAST);
    a_pulse_excl:  assert property (@(posedge clk) disable iff (rst) !(rise && fall));
    a_rise_single: assert property (@(posedge clk) disable iff (rst) rise |=> !rise);
    a_fall_single: assert property (@(posedge clk) disable iff (rst) fall |=> !fall);

endmodule

// File: rtl/procyon_debounce.sv
// Multi-lane debouncer: one independent procyon_debounce_lane per input bit.
module procyon_debounce
    import procyon_lib_pkg::*;
#(
    parameter int unsigned                OPTN_DATA_WIDTH      = 1,
    parameter int unsigned                OPTN_DEBOUNCE_CYCLES = 16,
    parameter logic [OPTN_DATA_WIDTH-1:0] OPTN_RESET_VAL       = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OPTN_DATA_WIDTH-1:0] i_sync_data,
    output logic [OPTN_DATA_WIDTH-1:0] o_level,
    output logic [OPTN_DATA_WIDTH-1:0] o_rise,
    output logic [OPTN_DATA_WIDTH-1:0] o_fall,
    output logic [OPTN_DATA_WIDTH-1:0] o_busy
);

    for (genvar i = 0; i < OPTN_DATA_WIDTH; i++) begin : g_lane
        procyon_debounce_lane #(
            .N         (OPTN_DEBOUNCE_CYCLES),
            .RESET_VAL (OPTN_RESET_VAL[i])
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .data  (i_sync_data[i]),
            .level (o_level[i]),
            .rise  (o_rise[i]),
            .fall  (o_fall[i]),
            .busy  (o_busy[i])
        );
    end

endmodule

// File: tb/tb_procyon_debounce.sv
// Self-checking bench for procyon_debounce (N=4, two lanes) against a run-length reference model.
module tb_procyon_debounce;

    localparam int unsigned N = 4;

    logic       clk;
    logic       rst;
    logic [1:0] din;
    logic [1:0] o_level, o_rise, o_fall, o_busy;
    logic [1:0] din_rv;
    logic [1:0] rv_level, rv_rise, rv_fall, rv_busy;

    int n_cmp;
    int n_bad;

    // Reference model: per lane, the stable level and the length of the current differing run.
    logic [1:0] m_level, m_rise, m_fall, m_busy;
    int         m_run [2];
    logic       rv_pulse;

    procyon_debounce #(
        .OPTN_DATA_WIDTH      (2),
        .OPTN_DEBOUNCE_CYCLES (N),
        .OPTN_RESET_VAL       (2'b00)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_sync_data (din),
        .o_level     (o_level),
        .o_rise      (o_rise),
        .o_fall      (o_fall),
        .o_busy      (o_busy)
    );

    procyon_debounce #(
        .OPTN_DATA_WIDTH      (2),
        .OPTN_DEBOUNCE_CYCLES (N),
        .OPTN_RESET_VAL       (2'b10)
    ) u_dut_rv (
        .clk         (clk),
        .rst         (rst),
        .i_sync_data (din_rv),
        .o_level     (rv_level),
        .o_rise      (rv_rise),
        .o_fall      (rv_fall),
        .o_busy      (rv_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [1:0] d, input logic r);
        din = d;
        rst = r;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (r) begin
                m_level[i] = 1'b0;
                m_run[i]   = 0;
            end else if (d[i] != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == int'(N)) begin
                    m_level[i] = d[i];
                    m_rise[i]  = d[i];
                    m_fall[i]  = !d[i];
                    m_run[i]   = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_busy[i] = (m_run[i] != 0);
        end
        #1;
        if (!r) rv_pulse = rv_pulse | (|rv_rise) | (|rv_fall);
    endtask

    task automatic test_reset();
        step(2'b11, 1'b1);
        step(2'b00, 1'b1);
        n_cmp++;
        if ({o_level, o_rise, o_fall, o_busy} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b", {o_level, o_rise, o_fall, o_busy}, 8'h00);
        end
        n_cmp++;
        if (rv_level !== 2'b10 || rv_busy !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_val_level: got level=%b busy=%b want level=10 busy=00", rv_level, rv_busy);
        end
    endtask

    task automatic test_step();
        logic [1:0] exp_lvl, exp_rise, exp_busy;
        step(2'b00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(2'b01, 1'b0);
            exp_lvl  = (k >= 3) ? 2'b01 : 2'b00;
            exp_rise = (k == 3) ? 2'b01 : 2'b00;
            exp_busy = (k < 3)  ? 2'b01 : 2'b00;
            n_cmp++;
            if (o_level !== exp_lvl || o_rise !== exp_rise || o_busy !== exp_busy || o_fall !== 2'b00) begin
                n_bad++;
                $display("FAIL step k=%0d: got lvl=%b rise=%b busy=%b fall=%b want lvl=%b rise=%b busy=%b fall=00",
                         k, o_level, o_rise, o_busy, o_fall, exp_lvl, exp_rise, exp_busy);
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] pat [4];
        int         busy_hi;
        int         busy_lo;
        pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b01; pat[3] = 2'b00;
        busy_hi = 0;
        busy_lo = 0;
        step(2'b00, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step(pat[k % 4], 1'b0);
            if (o_busy[0]) busy_hi++; else busy_lo++;
            n_cmp++;
            if (o_level[0] !== 1'b0 || o_rise[0] !== 1'b0 ||
                {o_level, o_rise, o_fall, o_busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_bad++;
                $display("FAIL glitch k=%0d: got %b want %b", k,
                         {o_level, o_rise, o_fall, o_busy}, {m_level, m_rise, m_fall, m_busy});
            end
        end
        n_cmp++;
        if (busy_hi == 0 || busy_lo == 0) begin
            n_bad++;
            $display("FAIL glitch_busy_toggle: got hi=%0d lo=%0d want both nonzero", busy_hi, busy_lo);
        end
    endtask

    task automatic test_fall();
        int falls;
        step(2'b00, 1'b1);
        for (int k = 0; k < 5; k++) step(2'b01, 1'b0);
        falls = 0;
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 1'b0);
            if (o_fall[0]) falls++;
        end
        step(2'b01, 1'b0);
        n_cmp++;
        if (o_level[0] !== 1'b1 || falls != 0) begin
            n_bad++;
            $display("FAIL fall_short_run: got lvl=%b falls=%0d want lvl=1 falls=0", o_level[0], falls);
        end
        for (int k = 0; k < 4; k++) begin
            step(2'b00, 1'b0);
            if (o_fall[0]) falls++;
            n_cmp++;
            if (o_fall[0] !== (k == 3) || o_level[0] !== (k != 3)) begin
                n_bad++;
                $display("FAIL fall k=%0d: got fall=%b lvl=%b want fall=%b lvl=%b",
                         k, o_fall[0], o_level[0], (k == 3), (k != 3));
            end
        end
        step(2'b00, 1'b0);
        n_cmp++;
        if (falls != 1 || o_fall[0] !== 1'b0 || o_level[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL fall_once: got falls=%0d fall=%b lvl=%b want falls=1 fall=0 lvl=0",
                     falls, o_fall[0], o_level[0]);
        end
    endtask

    task automatic test_reset_mid();
        step(2'b00, 1'b1);
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        step(2'b01, 1'b1);
        n_cmp++;
        if (o_busy[0] !== 1'b0 || o_rise[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_abandon: got busy=%b rise=%b want busy=0 rise=0", o_busy[0], o_rise[0]);
        end
        for (int k = 0; k < 6; k++) begin
            step(2'b01, 1'b0);
            n_cmp++;
            if (o_rise[0] !== (k == 3) || o_level[0] !== (k >= 3)) begin
                n_bad++;
                $display("FAIL reset_mid k=%0d: got rise=%b lvl=%b want rise=%b lvl=%b",
                         k, o_rise[0], o_level[0], (k == 3), (k >= 3));
            end
        end
    endtask

    task automatic test_independence();
        logic [1:0] d;
        step(2'b00, 1'b1);
        for (int c = 0; c < 13; c++) begin
            d[0] = (c >= 5);
            d[1] = (c >= 7);
            step(d, 1'b0);
            n_cmp++;
            if (o_rise[0] !== (c == 8) || o_rise[1] !== (c == 10) ||
                {o_level, o_rise, o_fall, o_busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_bad++;
                $display("FAIL independence c=%0d: got rise=%b all=%b want rise=%b%b all=%b", c, o_rise,
                         {o_level, o_rise, o_fall, o_busy}, (c == 10), (c == 8),
                         {m_level, m_rise, m_fall, m_busy});
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] d;
        logic [1:0] prev_rise, prev_fall;
        int         left [2];
        d = 2'b00;
        left[0] = 1;
        left[1] = 1;
        prev_rise = 2'b00;
        prev_fall = 2'b00;
        step(2'b00, 1'b1);
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 2; i++) begin
                left[i]--;
                if (left[i] == 0) begin
                    d[i]    = ~d[i];
                    left[i] = int'($urandom_range(1, 7));
                end
            end
            step(d, ($urandom_range(0, 59) == 0));
            n_cmp++;
            if ({o_level, o_rise, o_fall, o_busy} !== {m_level, m_rise, m_fall, m_busy}) begin
                n_bad++;
                $display("FAIL random k=%0d: got lvl=%b rise=%b fall=%b busy=%b want lvl=%b rise=%b fall=%b busy=%b",
                         k, o_level, o_rise, o_fall, o_busy, m_level, m_rise, m_fall, m_busy);
            end
            n_cmp++;
            if ((o_rise & o_fall) !== 2'b00 || (o_rise & prev_rise) !== 2'b00 || (o_fall & prev_fall) !== 2'b00) begin
                n_bad++;
                $display("FAIL random_pulse k=%0d: got rise=%b fall=%b prev_rise=%b prev_fall=%b want no overlap",
                         k, o_rise, o_fall, prev_rise, prev_fall);
            end
            prev_rise = o_rise;
            prev_fall = o_fall;
        end
    endtask

    task automatic test_reset_val();
        n_cmp++;
        if (rv_level !== 2'b10 || rv_pulse !== 1'b0 || rv_busy !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_val_hold: got lvl=%b pulse_seen=%b busy=%b want lvl=10 pulse_seen=0 busy=00",
                     rv_level, rv_pulse, rv_busy);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        din      = 2'b00;
        din_rv   = 2'b10;
        rst      = 1'b1;
        rv_pulse = 1'b0;
        m_level  = 2'b00;
        m_rise   = 2'b00;
        m_fall   = 2'b00;
        m_busy   = 2'b00;
        m_run[0] = 0;
        m_run[1] = 0;
        test_reset();
        test_step();
        test_glitch();
        test_fall();
        test_reset_mid();
        test_independence();
        test_random();
        test_reset_val();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
